// File: rtl/serial_complement_pkg.sv
// Shared definitions for the bit-serial complement unit: operation modes and FSM states.
package serial_complement_pkg;

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_ONES = 2'd1;
   localparam logic [1:0] MODE_TWOS = 2'd2;
   localparam logic [1:0] MODE_ABS  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_comp_cell.sv
// One-bit serial complement cell: once a set bit has been seen, later bits are
// inverted when negating; every bit is inverted for one's complement.
module serial_comp_cell (
   input  logic b,
   input  logic inv,
   input  logic neg,
   input  logic seen,
   output logic r,
   output logic seen_next
);

   assign r         = b ^ (inv | (neg & seen));
   assign seen_next = seen | b;

endmodule

// File: rtl/serial_complement.sv
// Bit-serial pass / one's / two's / absolute-value unit. One operand per
// valid/ready handshake, processed LSB-first at one bit per clock.
module serial_complement
   import serial_complement_pkg::*;
#(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             state;
   logic [WIDTH-1:0]   opnd;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         mode;
   logic               seen;
   logic               neg;
   logic               inv;
   logic               r_c;
   logic               seen_next_c;
   logic               last_bit_c;

   serial_comp_cell u_cell (
      .b         (opnd[0]),
      .inv       (inv),
      .neg       (neg),
      .seen      (seen),
      .r         (r_c),
      .seen_next (seen_next_c)
   );

   assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));

   // Control FSM and datapath; out_data doubles as the result shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         opnd      <= '0;
         cnt       <= '0;
         mode      <= MODE_PASS;
         seen      <= 1'b0;
         neg       <= 1'b0;
         inv       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  opnd     <= in_data;
                  mode     <= in_mode;
                  neg      <= (in_mode == MODE_TWOS) ||
                              ((in_mode == MODE_ABS) && in_data[WIDTH-1]);
                  inv      <= (in_mode == MODE_ONES);
                  cnt      <= '0;
                  seen     <= 1'b0;
                  out_ovf  <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               out_data <= {r_c, out_data[WIDTH-1:1]};
               opnd     <= opnd >> 1;
               seen     <= seen_next_c;
               cnt      <= cnt + CNT_W'(1);
               if (last_bit_c) begin
                  // Most negative value: sign bit set with no lower bit ever seen.
                  out_ovf   <= (mode != MODE_PASS) && neg && opnd[0] && !seen;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
